// File: rtl/rename_free_list.sv
// rtl/rename_free_list.sv - circular free list of physical register indices for rename
//
// Purpose: FIFO of free physical registers. Rename pops from the speculative
// head, commit pushes the displaced mapping at the tail. A retire head
// (rhead) tracks the architectural allocation point so that a flush can
// reclaim every speculative allocation in a single cycle.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   alloc_req        rename consumes pd_new this cycle
//   alloc_ok         list non-empty, pd_new valid
//   pd_new           physical register at the speculative head
//   commit_valid     retiring instruction releases commit_old_pd
//   commit_old_pd    displaced physical register returned to the list
//   flush_valid      recovery: head snaps back to the retire head
//   free_count       number of free entries
//   overflow_err     sticky, set when a release arrives while full
module rename_free_list #(
  parameter int LOG_REGS = 32,
  parameter int PHY_REGS = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alloc_req,
  output logic                        alloc_ok,
  output logic [$clog2(PHY_REGS)-1:0] pd_new,
  input  logic                        commit_valid,
  input  logic [$clog2(PHY_REGS)-1:0] commit_old_pd,
  input  logic                        flush_valid,
  output logic [$clog2(PHY_REGS-LOG_REGS):0] free_count,
  output logic                        overflow_err
);

  localparam int FL_DEPTH = PHY_REGS - LOG_REGS;
  localparam int PRF_BITS = $clog2(PHY_REGS);
  localparam int PTR_BITS = $clog2(FL_DEPTH) + 1;
  localparam int IDX_BITS = PTR_BITS - 1;

  logic [PRF_BITS-1:0] fl_mem [FL_DEPTH];
  logic [PTR_BITS-1:0] head, tail, rhead;
  logic [PTR_BITS-1:0] rhead_next;
  logic                full, enq, deq;

  // Pointers are {wrap, idx}; idx counts 0..FL_DEPTH-1 so a non power-of-two
  // depth still wraps correctly.
  function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
    if (p[IDX_BITS-1:0] == IDX_BITS'(FL_DEPTH - 1))
      return {~p[PTR_BITS-1], {IDX_BITS{1'b0}}};
    else
      return p + PTR_BITS'(1);
  endfunction

  // Entries from b up to (not including) a, honouring the wrap bit.
  function automatic logic [PTR_BITS-1:0] ptr_dist(input logic [PTR_BITS-1:0] a,
                                                   input logic [PTR_BITS-1:0] b);
    if (a[PTR_BITS-1] == b[PTR_BITS-1])
      return {1'b0, a[IDX_BITS-1:0] - b[IDX_BITS-1:0]};
    else
      return PTR_BITS'(FL_DEPTH) - {1'b0, b[IDX_BITS-1:0]} + {1'b0, a[IDX_BITS-1:0]};
  endfunction

  assign free_count = ptr_dist(tail, head);
  assign alloc_ok   = (free_count != '0);
  assign full       = (free_count == PTR_BITS'(FL_DEPTH));
  assign pd_new     = fl_mem[head[IDX_BITS-1:0]];

  // A release into a full list is dropped entirely (no pointer moves).
  assign enq        = commit_valid && !full;
  assign deq        = alloc_req && alloc_ok && !flush_valid;
  assign rhead_next = enq ? ptr_inc(rhead) : rhead;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++)
        fl_mem[i] <= PRF_BITS'(LOG_REGS + i);
      head         <= '0;
      rhead        <= '0;
      tail         <= {1'b1, {IDX_BITS{1'b0}}};
      overflow_err <= 1'b0;
    end else begin
      if (enq) begin
        fl_mem[tail[IDX_BITS-1:0]] <= commit_old_pd;
        tail                       <= ptr_inc(tail);
      end
      if (commit_valid && full)
        overflow_err <= 1'b1;
      rhead <= rhead_next;
      // Flush wins over allocation; the head lands on the retire head
      // including this cycle's commit.
      if (flush_valid)
        head <= rhead_next;
      else if (deq)
        head <= ptr_inc(head);
    end
  end

  // p0 belongs to x0 and must never be returned to the list.
  always_ff @(posedge clk) begin
    if (!rst && commit_valid)
      assert (commit_old_pd != '0);
  end

  // Everything between rhead and tail is either free or speculatively held.
  always_ff @(posedge clk) begin
    if (!rst)
      assert (ptr_dist(tail, rhead) == PTR_BITS'(FL_DEPTH));
  end

endmodule
